router_nx1_vc: RTL

- Parametrised successor of the fixed 3-input, 32-bit router: merges NUM_IN valid/ready input ports onto one output port.
- Each flit is classified into one of two classes, regular or priority, and buffered in a per-class FIFO.
- The output arbiter favours priority but guarantees regular-class forward progress through a starvation limit.
- Sits at a mesh merge point, upstream of a link or the next router.

---
 rtl/router_pkg.sv | 18 +
 rtl/router_fifo.sv | 63 ++++++
 rtl/router_nx1_vc.sv | 130 +++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared class encodings, default sizing and level-width helper for the
// NUM_IN-to-1 virtual-channel router.
package router_pkg;

  localparam logic CLS_REG  = 1'b0;
  localparam logic CLS_PRIO = 1'b1;

  localparam int NUM_IN_DEF     = 3;
  localparam int DATA_W_DEF     = 32;
  localparam int FIFO_AW_DEF    = 2;
  localparam int PRIO_BIT_DEF   = 31;
  localparam int STARVE_LIM_DEF = 4;

  function automatic int lvl_w(input int aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/router_fifo.sv
// Per-class flit FIFO: registered write, combinational head, occupancy level.
// A push while full is dropped even if a pop happens in the same cycle.
module router_fifo
  import router_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int FIFO_AW = FIFO_AW_DEF
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        push_i,
  input  logic [DATA_W-1:0]           wdata_i,
  input  logic                        pop_i,
  output logic [DATA_W-1:0]           rdata_o,
  output logic                        full_o,
  output logic                        empty_o,
  output logic [lvl_w(FIFO_AW)-1:0]   level_o
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int LW    = lvl_w(FIFO_AW);

  logic [DATA_W-1:0]  mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]      level_q, level_d;
  logic               do_push, do_pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      level_d = level_q + 1'b1;
    else if (!do_push && do_pop) level_d = level_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/router_nx1_vc.sv
// NUM_IN-to-1 flit router with regular/priority classes, per-class round-robin
// input arbitration, and a starvation-limited priority-first output arbiter.
module router_nx1_vc
  import router_pkg::*;
#(
  parameter int NUM_IN     = NUM_IN_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_AW    = FIFO_AW_DEF,
  parameter int PRIO_BIT   = PRIO_BIT_DEF,
  parameter int STARVE_LIM = STARVE_LIM_DEF
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [NUM_IN*DATA_W-1:0]   data_i,
  input  logic [NUM_IN-1:0]          valid_i,
  output logic [NUM_IN-1:0]          ready_o,
  output logic [DATA_W-1:0]          data_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [lvl_w(FIFO_AW)-1:0]  reg_level_o,
  output logic [lvl_w(FIFO_AW)-1:0]  prio_level_o
);

  localparam int LW    = lvl_w(FIFO_AW);
  localparam int PTR_W = $clog2(NUM_IN);
  localparam logic [7:0] LIM = 8'(STARVE_LIM);

  logic [NUM_IN-1:0] cls;
  logic [1:0]        full, empty, pop;
  logic [DATA_W-1:0] head  [2];
  logic [LW-1:0]     level [2];
  logic [NUM_IN-1:0] rdy   [2];

  for (genvar k = 0; k < NUM_IN; k++) begin : g_cls
    assign cls[k] = data_i[k*DATA_W + PRIO_BIT];
  end

  for (genvar c = 0; c < 2; c++) begin : g_vc
    localparam logic CLS = (c == 0) ? CLS_REG : CLS_PRIO;

    logic [PTR_W-1:0]  rr_q, rr_d, win;
    logic              found, push_c, full_c;
    logic [NUM_IN-1:0] req, gnt_c, rdy_c;
    logic [DATA_W-1:0] wdata_c;

    assign req = valid_i & (CLS ? cls : ~cls);

    // Search starts at the RR pointer so the last winner goes to the back.
    always_comb begin
      win   = '0;
      found = 1'b0;
      for (int i = 0; i < NUM_IN; i++) begin
        if (!found && req[(int'(rr_q) + i) % NUM_IN]) begin
          found = 1'b1;
          win   = PTR_W'((int'(rr_q) + i) % NUM_IN);
        end
      end
    end

    assign gnt_c   = found ? (NUM_IN'(1) << win) : '0;
    assign rdy_c   = gnt_c & {NUM_IN{rstn & ~full_c}};
    assign push_c  = |rdy_c;
    assign wdata_c = data_i[int'(win)*DATA_W +: DATA_W];
    assign rr_d    = !push_c ? rr_q
                   : (win == PTR_W'(NUM_IN - 1)) ? '0 : win + 1'b1;

    always_ff @(posedge clk) begin
      if (!rstn) rr_q <= '0;
      else       rr_q <= rr_d;
    end

    router_fifo #(
      .DATA_W  (DATA_W),
      .FIFO_AW (FIFO_AW)
    ) u_fifo (
      .clk     (clk),
      .rstn    (rstn),
      .push_i  (push_c),
      .wdata_i (wdata_c),
      .pop_i   (pop[c]),
      .rdata_o (head[c]),
      .full_o  (full_c),
      .empty_o (empty[c]),
      .level_o (level[c])
    );

    assign full[c] = full_c;
    assign rdy[c]  = rdy_c;
  end

  assign ready_o      = rdy[CLS_REG] | rdy[CLS_PRIO];
  assign reg_level_o  = level[CLS_REG];
  assign prio_level_o = level[CLS_PRIO];

  logic       lock_q, lock_d, lock_reg_q, lock_reg_d;
  logic       sel_reg_new, sel_reg, fire;
  logic [7:0] age_q, age_d;

  assign valid_o     = ~empty[CLS_PRIO] | ~empty[CLS_REG];
  assign sel_reg_new = empty[CLS_PRIO] | ((age_q == LIM) & ~empty[CLS_REG]);
  // A stalled output keeps its source so data_o cannot change under backpressure.
  assign sel_reg     = lock_q ? lock_reg_q : sel_reg_new;
  assign fire        = valid_o & ready_i;

  assign pop[CLS_REG]  = fire & sel_reg;
  assign pop[CLS_PRIO] = fire & ~sel_reg;
  assign data_o        = (valid_o & sel_reg) ? head[CLS_REG] : head[CLS_PRIO];

  assign lock_d     = valid_o & ~ready_i;
  assign lock_reg_d = sel_reg;

  always_comb begin
    age_d = age_q;
    if (empty[CLS_REG] || pop[CLS_REG])    age_d = '0;
    else if (pop[CLS_PRIO] && age_q != LIM) age_d = age_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      lock_q     <= 1'b0;
      lock_reg_q <= 1'b0;
      age_q      <= '0;
    end else begin
      lock_q     <= lock_d;
      lock_reg_q <= lock_reg_d;
      age_q      <= age_d;
    end
  end

endmodule
